// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector: runtime-loadable pattern, selectable overlap, saturating match counter.
// Optional SEQ_DETECT_REG_OUT_EN registers the match pulse (one cycle later) instead of the Mealy output.
module seq_detect_param #(
  parameter int unsigned      PAT_W    = 4,
  parameter logic [PAT_W-1:0] PAT_INIT = PAT_W'(4'b1011),
  parameter int unsigned      CNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       din,
  input  logic                       overlap,
  input  logic                       cfg_load,
  input  logic [PAT_W-1:0]           cfg_pattern,
  output logic                       match,
  output logic [CNT_W-1:0]           match_cnt,
  output logic [$clog2(PAT_W+1)-1:0] fill
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);
  localparam int unsigned HIST_W = PAT_W - 1;

  logic [PAT_W-1:0]  pat_q,  pat_d;
  logic [HIST_W-1:0] hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic [PAT_W-1:0]  window_c;
  logic              match_c;

  // Oldest bit sits in the MSB of the window; the incoming bit completes it.
  assign window_c = {hist_q, din};

  always_comb begin
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    match_c = in_valid & ~cfg_load & ~rst
            & (fill_q >= FILL_W'(PAT_W - 1))
            & (window_c == pat_q);
    if (cfg_load) begin
      pat_d  = cfg_pattern;
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (in_valid) begin
      hist_d = window_c[PAT_W-2:0];
      if (match_c) begin
        // Overlap keeps the whole window qualified; non-overlap demands PAT_W fresh bits.
        fill_d = overlap ? FILL_W'(PAT_W) : '0;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else if (fill_q != FILL_W'(PAT_W)) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= PAT_INIT;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
  assign fill      = fill_q;

`ifdef SEQ_DETECT_REG_OUT_EN
  logic match_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_c;
    end
  end

  assign match = match_q;
`else
  assign match = match_c;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed-vector bench for seq_detect_param (PAT_W=4); a second CNT_W=2 instance covers saturation.
module tb_seq_detect_param;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       din;
  logic       overlap;
  logic       cfg_load;
  logic [3:0] cfg_pattern;
  logic       match;
  logic [7:0] match_cnt;
  logic [2:0] fill;
  logic       match2;
  logic [1:0] match_cnt2;
  logic [2:0] fill2;

  int   n_vec;
  int   n_err;
  logic prev_m;

  seq_detect_param #(.PAT_W(4), .PAT_INIT(4'b1011), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din(din), .overlap(overlap),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .match(match), .match_cnt(match_cnt), .fill(fill)
  );

  seq_detect_param #(.PAT_W(4), .PAT_INIT(4'b1011), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din(din), .overlap(overlap),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .match(match2), .match_cnt(match_cnt2), .fill(fill2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock cycle of stimulus; match is checked mid-cycle against the expected pulse.
  task automatic cyc(input logic r, input logic v, input logic d, input logic ld,
                     input logic [3:0] p, input logic em, input string tag);
    rst = r; in_valid = v; din = d; cfg_load = ld; cfg_pattern = p;
    @(negedge clk);
`ifdef SEQ_DETECT_REG_OUT_EN
    chk(tag, 32'(match), 32'(prev_m));
    prev_m = em;
`else
    chk(tag, 32'(match), 32'(em));
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic d, input logic em, input string tag);
    cyc(1'b0, 1'b1, d, 1'b0, 4'h0, em, tag);
  endtask

  task automatic gap(input string tag);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, tag);
  endtask

  task automatic do_reset(input string tag);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, tag);
  endtask

  logic [16:0] sat_bits;
  logic [16:0] sat_m;
  int          sat_exp [5];
  int          mcnt;

  initial begin
    n_vec = 0; n_err = 0; prev_m = 1'b0;
    rst = 1'b1; in_valid = 1'b0; din = 1'b0; overlap = 1'b1; cfg_load = 1'b0; cfg_pattern = 4'h0;
    @(posedge clk);
    #1;

    // Reset state
    do_reset("rst_match");
    chk("rst_fill", 32'(fill), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);

    // Overlapping: 1011011 -> matches on bits 4 and 7
    overlap = 1'b1;
    bit_in(1'b1, 1'b0, "ov_b1");
    bit_in(1'b0, 1'b0, "ov_b2");
    bit_in(1'b1, 1'b0, "ov_b3");
    chk("ov_fill3", 32'(fill), 32'd3);
    bit_in(1'b1, 1'b1, "ov_b4");
    bit_in(1'b0, 1'b0, "ov_b5");
    bit_in(1'b1, 1'b0, "ov_b6");
    bit_in(1'b1, 1'b1, "ov_b7");
    chk("ov_cnt", 32'(match_cnt), 32'd2);
    chk("ov_fill", 32'(fill), 32'd4);

    // Non-overlapping: same stream -> only bit 4
    do_reset("no_rst");
    overlap = 1'b0;
    bit_in(1'b1, 1'b0, "no_b1");
    bit_in(1'b0, 1'b0, "no_b2");
    bit_in(1'b1, 1'b0, "no_b3");
    bit_in(1'b1, 1'b1, "no_b4");
    chk("no_fill4", 32'(fill), 32'd0);
    bit_in(1'b0, 1'b0, "no_b5");
    bit_in(1'b1, 1'b0, "no_b6");
    bit_in(1'b1, 1'b0, "no_b7");
    chk("no_fill7", 32'(fill), 32'd3);
    chk("no_cnt", 32'(match_cnt), 32'd1);

    // in_valid gaps between every bit
    do_reset("gap_rst");
    overlap = 1'b1;
    bit_in(1'b1, 1'b0, "gap_b1");
    gap("gap_g1");
    chk("gap_fill1", 32'(fill), 32'd1);
    bit_in(1'b0, 1'b0, "gap_b2");
    gap("gap_g2");
    chk("gap_fill2", 32'(fill), 32'd2);
    bit_in(1'b1, 1'b0, "gap_b3");
    gap("gap_g3");
    chk("gap_fill3", 32'(fill), 32'd3);
    bit_in(1'b1, 1'b1, "gap_b4");
    gap("gap_g4");
    chk("gap_cnt", 32'(match_cnt), 32'd1);

    // Runtime load of 0110 after 1,0,1 (counter was 1, must clear)
    bit_in(1'b1, 1'b0, "ld_p1");
    bit_in(1'b0, 1'b0, "ld_p2");
    bit_in(1'b1, 1'b0, "ld_p3");
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, "ld_cycle");
    chk("ld_fill", 32'(fill), 32'd0);
    chk("ld_cnt", 32'(match_cnt), 32'd0);
    bit_in(1'b0, 1'b0, "ld_b1");
    bit_in(1'b1, 1'b0, "ld_b2");
    bit_in(1'b1, 1'b0, "ld_b3");
    bit_in(1'b0, 1'b1, "ld_b4");
    chk("ld_cnt_after", 32'(match_cnt), 32'd1);

    // Saturation on the CNT_W=2 instance: five matches
    do_reset("sat_rst");
    overlap = 1'b1;
    sat_bits = 17'b10110110110111011;
    sat_m    = 17'b00010010010010001;
    sat_exp  = '{1, 2, 3, 3, 3};
    mcnt = 0;
    for (int i = 16; i >= 0; i--) begin
      bit_in(sat_bits[i], sat_m[i], "sat_bit");
      if (sat_m[i]) begin
        chk("sat_cnt2", 32'(match_cnt2), 32'(sat_exp[mcnt]));
        mcnt++;
      end
    end
    chk("sat_cnt8", 32'(match_cnt), 32'd5);

    // Reset mid-pattern discards history
    do_reset("mid_rst0");
    bit_in(1'b1, 1'b0, "mid_b1");
    bit_in(1'b0, 1'b0, "mid_b2");
    bit_in(1'b1, 1'b0, "mid_b3");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, "mid_rst");
    bit_in(1'b1, 1'b0, "mid_b4");
    chk("mid_fill", 32'(fill), 32'd1);
    chk("mid_cnt", 32'(match_cnt), 32'd0);
    gap("tail");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial pattern detector; the successor to the fixed 4-bit "1011" Mealy detector.
- Pattern width is set by a parameter and the pattern is loadable at runtime; overlapping or non-overlapping detection is selectable per cycle.
- Input accepts a valid-qualified bit stream; output gives a Mealy match pulse and a saturating match counter.
- Sits after the serial bit-stream front end; feeds the event/interrupt logic.

Parameters:
- PAT_W, 4, pattern length in bits (legal range 2..32).
- PAT_INIT, 4'b1011 (PAT_W bits), pattern value after reset.
- CNT_W, 8, width of the match counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  din is sampled this cycle.
- din  in  1  serial data bit.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping; sampled in each accepted cycle.
- cfg_load  in  1  load cfg_pattern this cycle.
- cfg_pattern  in  PAT_W  new pattern; first-received bit is the MSB.
- match  out  1  pattern completed by the current bit.
- match_cnt  out  CNT_W  number of matches since reset or load; saturates.
- fill  out  $clog2(PAT_W+1)  history bits currently qualifying (0..PAT_W).

Behaviour:
- Reset (synchronous, active-high): pat_reg=PAT_INIT, hist=0, fill=0, match_cnt=0, match=0.
- Storage: hist register, PAT_W-1 bits, newest bit in the LSB; fill counter saturates at PAT_W.
- Window = {hist, din}; its MSB is the oldest bit.
- Match, combinational Mealy output with zero latency:
  - match = in_valid & ~cfg_load & ~rst & (fill >= PAT_W-1) & (window == pat_reg).
- Accepted cycle (in_valid=1, cfg_load=0, no match): hist <= window[PAT_W-2:0]; fill <= min(fill+1, PAT_W).
- Match with overlap=1: hist shifts as above; fill <= PAT_W; the suffix can begin the next match (1011011 gives 2 matches).
- Match with overlap=0: hist shifts; fill <= 0, so the next match needs PAT_W fresh bits.
- On match: match_cnt <= match_cnt+1, saturating at 2^CNT_W-1 (no wrap).
- in_valid=0: all state holds; match=0.
- cfg_load=1: pat_reg <= cfg_pattern; hist, fill and match_cnt cleared.
  - cfg_load has priority over in_valid in the same cycle; that din is discarded and match=0.
- rst has priority over cfg_load and in_valid.
- rst mid-stream: everything returns to reset values at the next edge; a partial pattern is lost.
- Bit accepted in the first cycle after reset/load: fill=0, so no match is possible until PAT_W bits have been accepted.

Optional Feature:
- Macro: SEQ_DETECT_REG_OUT_EN.
- Defined: match is registered (Moore-style).
  - It asserts one cycle after the completing bit.
  - Reset value 0.
  - A cfg_load in the following cycle does not suppress an already-registered pulse.
  - match_cnt timing is unchanged.
- Undefined: combinational Mealy match as specified above.

Test Plan:
- PAT_W=4, default pattern, overlap=1, stream 1,0,1,1,0,1,1 (in_valid=1 every cycle):
  - match high on bits 4 and 7 only; match_cnt=2; fill=4 at end.
- Same stream with overlap=0:
  - match only on bit 4; fill=0 after bit 4, then 3 after bit 7; match_cnt=1.
- Stream 1,0,1,1 with in_valid=0 inserted between every bit:
  - match on the 4th valid bit only; hist and fill unchanged in gap cycles.
- cfg_load with cfg_pattern=4'b0110 after input 1,0,1, then 0,1,1,0:
  - no match on the load cycle; match on the final 0; match_cnt=1.
- CNT_W=2, overlap=1, stream 1011011011011 (4 matches), then 1011 (5th match):
  - match_cnt reads 3 after the 3rd match and stays 3 through the 4th and 5th.
- rst asserted after 1,0,1, then 1 applied:
  - no match; fill=1 after the following bit; with SEQ_DETECT_REG_OUT_EN, match observed one cycle after the completing bit in the first test.
